shift_reg_univ: RTL

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

---
 rtl/shift_reg_pkg.sv | 33 +++
 rtl/sr_step_logic.sv | 60 ++++++
 rtl/shift_reg_univ.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register: operation modes,
// shift directions and the sequencer state codes.
package shift_reg_pkg;

    // Operation select (MODE input)
    localparam logic [2:0] MODE_SHIFT  = 3'b000;
    localparam logic [2:0] MODE_ROTATE = 3'b001;
    localparam logic [2:0] MODE_LOAD   = 3'b010;
    localparam logic [2:0] MODE_HOLD   = 3'b011;
    localparam logic [2:0] MODE_ARITH  = 3'b100;

    // Direction select (DIR input)
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Sequencer states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_FIN  = 2'b10;

    // Only the shifting modes can be repeated by the sequencer.
    function automatic logic is_seq_mode(input logic [2:0] mode);
        logic res;
        case (mode)
            MODE_SHIFT:  res = 1'b1;
            MODE_ROTATE: res = 1'b1;
            MODE_ARITH:  res = 1'b1;
            default:     res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sr_step_logic.sv
// Combinational single-step next value and serial-out bit for one
// shift/rotate/arithmetic/load/hold operation.
module sr_step_logic
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             s_out_i,
    input  logic [2:0]       mode_i,
    input  logic             dir_i,
    input  logic             s_in_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             s_out_o
);

    // Select the next register value and the bit that falls off the end.
    always_comb begin
        q_o     = q_i;
        s_out_o = s_out_i;
        case (mode_i)
            MODE_SHIFT: begin
                if (dir_i == DIR_LEFT) begin
                    q_o     = {q_i[WIDTH-2:0], s_in_i};
                    s_out_o = q_i[WIDTH-1];
                end else begin
                    q_o     = {s_in_i, q_i[WIDTH-1:1]};
                    s_out_o = q_i[0];
                end
            end
            MODE_ROTATE: begin
                if (dir_i == DIR_LEFT) begin
                    q_o     = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                    s_out_o = q_i[WIDTH-1];
                end else begin
                    q_o     = {q_i[0], q_i[WIDTH-1:1]};
                    s_out_o = q_i[0];
                end
            end
            MODE_LOAD: begin
                q_o = d_i;
            end
            MODE_ARITH: begin
                if (dir_i == DIR_LEFT) begin
                    q_o     = {q_i[WIDTH-2:0], 1'b0};
                    s_out_o = q_i[WIDTH-1];
                end else begin
                    q_o     = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
                    s_out_o = q_i[0];
                end
            end
            default: begin
                q_o     = q_i;
                s_out_o = s_out_i;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with a small sequencer that repeats a shift,
// rotate or arithmetic step AMT times after a START request.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET_L,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic [CNT_W-1:0] AMT,
    input  logic             START,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             s_out_q, s_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2:0]       step_mode_s;
    logic             step_dir_s;
    logic [WIDTH-1:0] step_q_s;
    logic             step_s_out_s;

    // While sequencing, the captured operation drives the shared step logic.
    always_comb begin
        if (state_q == ST_RUN) begin
            step_mode_s = mode_q;
            step_dir_s  = dir_q;
        end else begin
            step_mode_s = MODE;
            step_dir_s  = DIR;
        end
    end

    sr_step_logic #(
        .WIDTH (WIDTH)
    ) u_step (
        .q_i     (q_q),
        .s_out_i (s_out_q),
        .mode_i  (step_mode_s),
        .dir_i   (step_dir_s),
        .s_in_i  (S_IN),
        .d_i     (D),
        .q_o     (step_q_s),
        .s_out_o (step_s_out_s)
    );

    // Sequencer next-state, step counter and data-path update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        q_d     = q_q;
        s_out_d = s_out_q;
        if (ENB) begin
            case (state_q)
                ST_IDLE: begin
                    if (START && is_seq_mode(MODE)) begin
                        mode_d = MODE;
                        dir_d  = DIR;
                        cnt_d  = AMT;
                        if (AMT == CNT_ZERO) begin
                            state_d = ST_FIN;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        q_d     = step_q_s;
                        s_out_d = step_s_out_s;
                    end
                end
                ST_RUN: begin
                    q_d     = step_q_s;
                    s_out_d = step_s_out_s;
                    cnt_d   = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Status flags are decoded from the next state so they leave a flop.
    always_comb begin
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_FIN);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET_L) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            mode_q  <= MODE_SHIFT;
            dir_q   <= DIR_LEFT;
            q_q     <= {WIDTH{1'b0}};
            s_out_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            q_q     <= q_d;
            s_out_q <= s_out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Q     = q_q;
    assign S_OUT = s_out_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;

endmodule
